// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers.
// Sits beside the EX-stage ALU and stalls the front end while it iterates.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               is_div;
  logic               sa;
  logic               sb;
  logic               bzero;

  logic               op_md;
  logic               op_mthi;
  logic               op_mtlo;
  logic               go;
  logic               mt_ok;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  logic [2*WIDTH-1:0] prod_fx;
  logic [WIDTH-1:0]   quo_fx;
  logic [WIDTH-1:0]   rem_fx;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Opcode decode: codes 000..011 are the iterative ops.
  assign op_md   = (i_op[2] == 1'b0);
  assign op_mthi = (i_op == 3'b100);
  assign op_mtlo = (i_op == 3'b101);

  assign go    = (state == IDLE) && i_start && !i_flush && op_md;
  assign mt_ok = (state == IDLE) && i_start && !i_flush;

  // Signed ops have op[0]==0; unsigned ops never see a sign flag.
  assign a_neg = !i_op[0] && i_a[WIDTH-1];
  assign b_neg = !i_op[0] && i_b[WIDTH-1];
  assign a_mag = a_neg ? -i_a : i_a;
  assign b_mag = b_neg ? -i_b : i_b;

  // One shift-add or restoring-divide step on the shared accumulator.
  // Divide keeps remainder in the upper half and quotient in the lower.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, mag_b} : '0);
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    if (is_div) begin
      if (!div_trial[WIDTH])
        acc_n = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_n = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_n = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction and result selection used during FIX.
  always_comb begin
    prod_fx = (sa ^ sb) ? -acc : acc;
    quo_fx  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fx  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod_fx[2*WIDTH-1:WIDTH];
      fix_lo = prod_fx[WIDTH-1:0];
    end else if (bzero) begin
      fix_hi = raw_a;
      fix_lo = '1;
    end else begin
      fix_hi = rem_fx;
      fix_lo = quo_fx;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and stall; a flush wins in every state.
  always_comb begin
    state_n = state;
    o_stall = 1'b0;
    case (state)
      IDLE: begin
        o_stall = i_start && op_md;
        if (go) state_n = CALC;
      end
      CALC: begin
        o_stall = 1'b1;
        if (cnt == LAST) state_n = FIX;
      end
      FIX: begin
        o_stall = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (i_flush) begin
      state_n = IDLE;
      o_stall = 1'b0;
    end
  end

  // Operand latch at accept, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mag_b  <= '0;
      raw_a  <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bzero  <= 1'b0;
    end else if (go) begin
      cnt    <= '0;
      acc    <= {{WIDTH{1'b0}}, a_mag};
      mag_b  <= b_mag;
      raw_a  <= i_a;
      is_div <= i_op[1];
      sa     <= a_neg;
      sb     <= b_neg;
      bzero  <= (i_b == '0);
    end else if (state == CALC) begin
      acc <= acc_n;
      cnt <= cnt + 1'b1;
    end
  end

  // HI/LO: MTHI/MTLO from IDLE, results at the end of FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (!i_flush) begin
      if (mt_ok && op_mthi) hi <= i_a;
      if (mt_ok && op_mtlo) lo <= i_a;
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

  assign o_busy = (state == CALC) || (state == FIX);
  assign o_done = (state == DONE);
  assign o_hi   = hi;
  assign o_lo   = lo;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed table, hand sequences and random ops
// checked against an arithmetic reference model.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        o_stall;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_flush (i_flush),
    .o_stall (o_stall),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural values.
  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      sa;
    longint      sb;
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'h0;
    lo = 32'h0;
    case (op)
      3'd0: begin
        sp = sa * sb;
        up = 64'(sp);
        hi = up[63:32];
        lo = up[31:0];
      end
      3'd1: begin
        up = {32'h0, a} * {32'h0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFFFFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          lo = 32'(sq);
          hi = 32'(sr);
        end
      end
      default: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFFFFFF;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Entered and left just after a rising edge; i_start held until DONE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int stalls,
                        output bit done, output logic [31:0] hi,
                        output logic [31:0] lo);
    i_start = 1'b1;
    i_op = op;
    i_a = a;
    i_b = b;
    stalls = 0;
    done = 1'b0;
    hi = 32'hx;
    lo = 32'hx;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (o_stall) stalls++;
      if (o_done) begin
        done = 1'b1;
        hi = o_hi;
        lo = o_lo;
      end
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
    int          st;
    bit          dn;
    logic [31:0] h;
    logic [31:0] l;
    run_op(op, a, b, st, dn, h, l);
    chk({tag, "_done"}, 32'(dn), 32'd1);
    chk({tag, "_stalls"}, 32'(st), 32'd34);
    chk({tag, "_hi"}, h, ehi);
    chk({tag, "_lo"}, l, elo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    i_start = 1'b1;
    i_op = op;
    i_a = v;
    @(negedge clk);
    chk("mt_stall", 32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic flush_run(input string tag, input int at);
    int dones;
    i_start = 1'b1;
    i_op = 3'b011;
    i_a = 32'd9;
    i_b = 32'd2;
    for (int k = 0; k < at; k++) begin
      @(posedge clk);
      #1;
    end
    i_flush = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_before"}, 32'(o_busy), 32'd1);
    chk({tag, "_stall_flush"}, 32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    chk({tag, "_no_done"}, 32'(dones), 32'd0);
    chk({tag, "_hi"}, o_hi, 32'hAAAA5555);
    chk({tag, "_lo"}, o_lo, 32'hAAAA5555);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    int          st;
    bit          dn;
    logic [31:0] h;
    logic [31:0] l;

    vecs.push_back('{3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1});
    vecs.push_back('{3'd3, 32'd100, 32'd7, 32'd2, 32'd14});
    vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
    vecs.push_back('{3'd3, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF});
    vecs.push_back('{3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF});
    vecs.push_back('{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
    vecs.push_back('{3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD});

    reset = 1'b1;
    i_start = 1'b0;
    i_op = 3'd0;
    i_a = 32'h0;
    i_b = 32'h0;
    i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_hi", o_hi, 32'h0);
    chk("rst_lo", o_lo, 32'h0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors, issued back to back.
    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo);

    // o_done is a single-cycle pulse.
    @(negedge clk);
    chk("done_pulse", 32'(o_done), 32'd0);
    @(posedge clk);
    #1;

    // MTHI/MTLO on consecutive cycles, then an ignored opcode.
    mt(3'b100, 32'h12345678);
    chk("mthi_hi", o_hi, 32'h12345678);
    mt(3'b101, 32'h9ABCDEF0);
    chk("mtlo_lo", o_lo, 32'h9ABCDEF0);
    chk("mtlo_hi", o_hi, 32'h12345678);
    mt(3'b110, 32'h55555555);
    chk("nop_hi", o_hi, 32'h12345678);
    chk("nop_lo", o_lo, 32'h9ABCDEF0);

    // MULT then DIVU back to back.
    check_op("b2b_mul", 3'd0, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF,
             32'hFFFFFFD6);
    check_op("b2b_div", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    // Flush in CALC and in FIX.
    mt(3'b100, 32'hAAAA5555);
    mt(3'b101, 32'hAAAA5555);
    flush_run("flush_calc", 10);
    flush_run("flush_fix", 33);

    // Reset in the middle of CALC.
    i_start = 1'b1;
    i_op = 3'd0;
    i_a = 32'd5;
    i_b = 32'd5;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    i_start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_stall", 32'(o_stall), 32'd0);
    chk("midrst_hi", o_hi, 32'h0);
    chk("midrst_lo", o_lo, 32'h0);
    @(posedge clk);
    #1;

    // Random ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = 32'h0;
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      model(rop, ra, rb, eh, el);
      run_op(rop, ra, rb, st, dn, h, l);
      chk($sformatf("rnd%0d_done", n), 32'(dn), 32'd1);
      chk($sformatf("rnd%0d_stalls", n), 32'(st), 32'd34);
      chk($sformatf("rnd%0d_hi op%0d %h %h", n, rop, ra, rb), h, eh);
      chk($sformatf("rnd%0d_lo op%0d %h %h", n, rop, ra, rb), l, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer with HI/LO registers, sitting beside the ALU in the EX stage of the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-iteration shift-add or restoring-divide datapath.
- Drives a pipeline stall until the result lands in HI/LO.
- Also services single-cycle MTHI/MTLO writes; MFHI/MFLO read o_hi/o_lo directly.

Parameters:
- WIDTH, 32, operand width. The only supported value is 32. The iteration counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_start  input  1  EX holds an MDU instruction. Stays high while the pipeline is stalled.
- i_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Other codes are no-ops.
- i_a  input  32  rs operand, already forwarded
- i_b  input  32  rt operand, already forwarded
- i_flush  input  1  exception/flush of the EX instruction
- o_stall  output  1  freeze IF/ID/EX (combinational)
- o_busy  output  1  state is CALC or FIX (registered)
- o_done  output  1  one-cycle pulse, asserted in the cycle new HI/LO values are first visible
- o_hi  output  32  HI register
- o_lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, HI=0, LO=0, o_busy=0, o_done=0, counter=0. Reset overrides everything, including an operation in progress; HI/LO are cleared even mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - i_start & !i_flush & op in {MULT, MULTU, DIV, DIVU}: latch |i_a|, |i_b| (magnitude only for signed ops), sign flags sa/sb, raw i_a; counter=0; go to CALC.
  - i_start & !i_flush & MTHI: HI<=i_a at the clock edge. MTLO: LO<=i_a. Stay in IDLE, no stall, no o_done.
  - Undefined op codes: ignored, no stall.
- CALC: one iteration per cycle on magnitudes.
  - Multiply: 64-bit shift-add.
  - Divide: restoring; 32-bit partial remainder plus quotient shift register.
  - Go to FIX when counter==31 (32 CALC cycles total).
- FIX:
  - Sign correction. Product is negated if sa^sb (signed ops only). Quotient is negated if sa^sb; remainder is negated if sa (signed ops only).
  - Multiply writes HI=prod[63:32], LO=prod[31:0]. Divide writes LO=quotient, HI=remainder.
  - HI/LO are written at the edge ending FIX; next state is DONE.
- Divide by zero (i_b==0, latched): latency is unchanged. FIX writes LO=32'hFFFFFFFF, HI=raw i_a, regardless of signedness.
- Signed overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0. This falls out of magnitude arithmetic and needs no special case.
- DONE: o_done=1, o_stall=0. i_start is ignored, because the finished instruction is still in EX this cycle. Unconditionally go to IDLE.
- Latency: accept in cycle T; CALC T+1..T+32; FIX T+33; DONE T+34, when new HI/LO are visible.
- o_stall = ((IDLE & i_start & mul/div op) | CALC | FIX) & !i_flush. This is high for exactly 34 cycles, T..T+33.
- i_flush, any state: go to IDLE at the next edge. HI/LO are not written, including when the flush arrives in FIX. o_stall drops combinationally in the same cycle.
- o_busy is high in CALC and FIX only.
- No forwarding of in-flight results. An MFHI behind a divide is covered by the stall.
- Back-to-back MDU ops: the second op reaches EX at T+35 in IDLE and restarts normally.
- MTHI/MTLO are never accepted outside IDLE.

Test Plan:
- Reset, then idle 5 cycles -> o_hi=o_lo=0, o_stall=0, o_done=0. Assert reset mid-CALC -> next cycle state IDLE, HI=LO=0, o_stall=0.
- MULT i_a=-3 (FFFFFFFD), i_b=7, i_start held while o_stall -> o_stall high 34 cycles; at T+34 o_done=1, HI=FFFFFFFF, LO=FFFFFFEB. MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- DIVU 1234/0 and DIV -5/0 -> after 34 stall cycles, LO=FFFFFFFF with HI=1234 and HI=FFFFFFFB respectively.
- With HI=LO=AAAA5555, start DIVU 9/2 and assert i_flush at CALC cycle 10 -> o_stall=0 in that cycle, IDLE next, HI/LO still AAAA5555, no o_done. Repeat with the flush in FIX -> same result.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> o_stall never high, HI/LO updated one edge after each. Then a DIVU issued right after a completed MULT -> the second op starts in IDLE after DONE with correct results.
